mips32_run_ctrl: RTL and testbench



---
 rtl/mips32_run_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mips32_run_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mips32_run_ctrl.sv
// Run controller for a small MIPS32 core: program load into instruction memory,
// pipeline clear, run with watchdog, drain after halt, and halted/done reporting.
module mips32_run_ctrl #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned FLUSH_CYC = 5,
  parameter int unsigned DRAIN_CYC = 4,
  parameter int unsigned WDOG_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              start,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              hlt,
  output logic              fetch_en,
  output logic              pipe_en,
  output logic              pipe_flush,
  output logic              pc_clr,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [ADDR_W:0]   prog_len,
  output logic [WDOG_W-1:0] run_cycles
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_CLEAR  = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;

  localparam int unsigned CNT_MAX = (FLUSH_CYC > DRAIN_CYC) ? FLUSH_CYC : DRAIN_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [ADDR_W:0]   PROG_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [WDOG_W-1:0] WDOG_MAX  = {WDOG_W{1'b1}};

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W:0]   prog_len_q, prog_len_d;
  logic [WDOG_W-1:0] run_cycles_q, run_cycles_d;
  logic [1:0]        err_q, err_d;
  logic              fetch_en_q, fetch_en_d;
  logic              pipe_en_q, pipe_en_d;
  logic              pipe_flush_q, pipe_flush_d;
  logic              pc_clr_q, pc_clr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              full;
  logic              hs;
  logic [WDOG_W-1:0] run_inc;

  // Next-state, counters and the combinational load-port strobes
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    prog_len_d   = prog_len_q;
    run_cycles_d = run_cycles_q;
    err_d        = err_q;

    ld_ready   = (state_q == S_LOAD);
    full       = (prog_len_q == PROG_FULL);
    hs         = ld_valid && ld_ready;
    imem_we    = hs && !full;
    imem_addr  = prog_len_q[ADDR_W-1:0];
    imem_wdata = ld_data;
    run_inc    = (run_cycles_q == WDOG_MAX) ? run_cycles_q : run_cycles_q + WDOG_W'(1);

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (load_req) begin
          state_d    = S_LOAD;
          prog_len_d = '0;
        end else if (start) begin
          state_d      = S_CLEAR;
          cnt_d        = '0;
          run_cycles_d = '0;
          err_d[1]     = 1'b0;
        end
      end
      S_LOAD: begin
        if (hs) begin
          if (full) begin
            err_d[0] = 1'b1;
            state_d  = S_IDLE;
          end else begin
            prog_len_d = prog_len_q + (ADDR_W+1)'(1);
            if (ld_last) state_d = S_IDLE;
          end
        end
      end
      S_CLEAR: begin
        if (cnt_q == CNT_W'(FLUSH_CYC - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        run_cycles_d = run_inc;
        // A halt seen on the watchdog's final cycle still gets a normal drain
        if (hlt) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else if (run_inc == WDOG_MAX) begin
          err_d[1] = 1'b1;
          state_d  = S_HALTED;
        end
      end
      S_DRAIN: begin
        run_cycles_d = run_inc;
        if (cnt_q == CNT_W'(DRAIN_CYC - 1)) begin
          state_d = S_HALTED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    fetch_en_d   = (state_d == S_RUN);
    pipe_en_d    = (state_d == S_CLEAR) || (state_d == S_RUN) || (state_d == S_DRAIN);
    pipe_flush_d = (state_d == S_CLEAR);
    pc_clr_d     = (state_d == S_CLEAR);
    busy_d       = (state_d != S_IDLE) && (state_d != S_HALTED);
    done_d       = (state_d == S_HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      prog_len_q   <= '0;
      run_cycles_q <= '0;
      err_q        <= '0;
      fetch_en_q   <= 1'b0;
      pipe_en_q    <= 1'b0;
      pipe_flush_q <= 1'b0;
      pc_clr_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prog_len_q   <= prog_len_d;
      run_cycles_q <= run_cycles_d;
      err_q        <= err_d;
      fetch_en_q   <= fetch_en_d;
      pipe_en_q    <= pipe_en_d;
      pipe_flush_q <= pipe_flush_d;
      pc_clr_q     <= pc_clr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign fetch_en   = fetch_en_q;
  assign pipe_en    = pipe_en_q;
  assign pipe_flush = pipe_flush_q;
  assign pc_clr     = pc_clr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign prog_len   = prog_len_q;
  assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_mips32_run_ctrl.sv
// Directed bench for mips32_run_ctrl: load, run/drain, overflow, async reset,
// command priority, and a narrow-watchdog instance for the timeout path.
module tb_mips32_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_req = 1'b0, start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0, hlt = 1'b0;
  logic [31:0] ld_data = '0;
  logic        ld_ready, imem_we, fetch_en, pipe_en, pipe_flush, pc_clr, busy, done;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [1:0]  err;
  logic [10:0] prog_len;
  logic [15:0] run_cycles;

  logic        start_w = 1'b0;
  logic        ld_ready_w, imem_we_w, fetch_en_w, pipe_en_w, pipe_flush_w, pc_clr_w, busy_w, done_w;
  logic [9:0]  imem_addr_w;
  logic [31:0] imem_wdata_w;
  logic [1:0]  err_w;
  logic [10:0] prog_len_w;
  logic [3:0]  run_cycles_w;

  int n_assert = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int addr_err = 0;
  logic [31:0] mem [0:1023];

  mips32_run_ctrl dut (
    .clk(clk), .rst(rst), .load_req(load_req), .start(start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .hlt(hlt),
    .fetch_en(fetch_en), .pipe_en(pipe_en), .pipe_flush(pipe_flush), .pc_clr(pc_clr),
    .busy(busy), .done(done), .err(err), .prog_len(prog_len), .run_cycles(run_cycles)
  );

  mips32_run_ctrl #(.WDOG_W(4)) dut_w (
    .clk(clk), .rst(rst), .load_req(1'b0), .start(start_w),
    .ld_valid(1'b0), .ld_data(32'h0), .ld_last(1'b0), .ld_ready(ld_ready_w),
    .imem_we(imem_we_w), .imem_addr(imem_addr_w), .imem_wdata(imem_wdata_w), .hlt(1'b0),
    .fetch_en(fetch_en_w), .pipe_en(pipe_en_w), .pipe_flush(pipe_flush_w), .pc_clr(pc_clr_w),
    .busy(busy_w), .done(done_w), .err(err_w), .prog_len(prog_len_w), .run_cycles(run_cycles_w)
  );

  always #5 clk = ~clk;

  // Instruction-memory model: records writes and checks the address sequence
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      if (imem_addr != 10'(wr_cnt)) addr_err++;
      mem[imem_addr] = imem_wdata;
      wr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int flush_cnt, drain_cnt, bad, run_cnt, drain_w;

    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_prog_len", 64'(prog_len), 64'd0);
    check("rst_run_cycles", 64'(run_cycles), 64'd0);
    check("rst_fetch_en", 64'(fetch_en), 64'd0);
    check("rst_ld_ready", 64'(ld_ready), 64'd0);
    step();
    rst = 1'b0;

    // Three-word program load; start in LOAD must be ignored
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    check("load_ready", 64'(ld_ready), 64'd1);
    check("load_busy", 64'(busy), 64'd1);
    ld_valid = 1'b1; ld_data = 32'h0022_1800;
    step();
    ld_data = 32'h0422_1800; start = 1'b1;
    step();
    start = 1'b0; ld_data = 32'hFC00_0000; ld_last = 1'b1;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
    check("load3_prog_len", 64'(prog_len), 64'd3);
    check("load3_idle_ready", 64'(ld_ready), 64'd0);
    check("load3_idle_busy", 64'(busy), 64'd0);
    check("load3_err", 64'(err), 64'd0);
    check("load3_writes", 64'(wr_cnt), 64'd3);
    check("load3_mem0", 64'(mem[0]), 64'h0022_1800);
    check("load3_mem1", 64'(mem[1]), 64'h0422_1800);
    check("load3_mem2", 64'(mem[2]), 64'hFC00_0000);
    check("load3_addr_seq", 64'(addr_err), 64'd0);

    // Run: flush, 11 RUN cycles (hlt on the 11th), drain, halted
    start = 1'b1;
    step();
    start = 1'b0;
    check("clear_flush", 64'(pipe_flush), 64'd1);
    flush_cnt = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (fetch_en) break;
      if (pipe_flush) flush_cnt++;
      if (!(pc_clr && pipe_en)) bad++;
      start = (i == 2);
      step();
    end
    start = 1'b0;
    check("clear_cycles", 64'(flush_cnt), 64'd5);
    check("clear_pc_clr_pipe_en", 64'(bad), 64'd0);
    check("run_entry_fetch", 64'(fetch_en), 64'd1);
    check("run_entry_cycles", 64'(run_cycles), 64'd0);
    for (int k = 0; k < 10; k++) begin
      start = (k == 3);
      step();
    end
    start = 1'b0;
    check("run10_cycles", 64'(run_cycles), 64'd10);
    check("hlt_cycle_fetch", 64'(fetch_en), 64'd1);
    hlt = 1'b1;
    step();
    hlt = 1'b0;
    check("drain_fetch", 64'(fetch_en), 64'd0);
    check("drain_pipe_en", 64'(pipe_en), 64'd1);
    drain_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      if (!fetch_en && pipe_en) drain_cnt++;
      step();
    end
    check("drain_cycles", 64'(drain_cnt), 64'd4);
    check("halt_done", 64'(done), 64'd1);
    check("halt_busy", 64'(busy), 64'd0);
    check("halt_pipe_en", 64'(pipe_en), 64'd0);
    check("halt_run_cycles", 64'(run_cycles), 64'd15);
    check("halt_err", 64'(err), 64'd0);

    // load_req beats start from HALTED, then overflow with 1025 words
    load_req = 1'b1; start = 1'b1;
    step();
    load_req = 1'b0; start = 1'b0;
    check("prio_load", 64'(ld_ready), 64'd1);
    check("prio_no_flush", 64'(pipe_flush), 64'd0);
    check("prio_prog_len_clr", 64'(prog_len), 64'd0);
    wr_cnt = 0; addr_err = 0;
    ld_valid = 1'b1;
    for (int i = 0; i < 1025; i++) begin
      ld_data = 32'(i) ^ 32'hA5A5_0000;
      step();
    end
    ld_valid = 1'b0;
    check("ovf_err", 64'(err), 64'd1);
    check("ovf_prog_len", 64'(prog_len), 64'd1024);
    check("ovf_writes", 64'(wr_cnt), 64'd1024);
    check("ovf_idle", 64'(ld_ready), 64'd0);
    check("ovf_addr_seq", 64'(addr_err), 64'd0);
    check("ovf_mem_last", 64'(mem[1023]), 64'hA5A5_03FF);

    // Async reset between edges in RUN
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (fetch_en) break;
      step();
    end
    step(); step(); step();
    check("pre_rst_fetch", 64'(fetch_en), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_fetch", 64'(fetch_en), 64'd0);
    check("arst_pipe_en", 64'(pipe_en), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_run_cycles", 64'(run_cycles), 64'd0);
    check("arst_err", 64'(err), 64'd0);
    check("arst_prog_len", 64'(prog_len), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("post_rst_clear", 64'(pipe_flush), 64'd1);
    check("post_rst_busy", 64'(busy), 64'd1);

    // Watchdog timeout on the 4-bit instance
    start_w = 1'b1;
    step();
    start_w = 1'b0;
    run_cnt = 0; drain_w = 0;
    for (int i = 0; i < 60; i++) begin
      if (done_w) break;
      if (fetch_en_w) run_cnt++;
      if (pipe_en_w && !fetch_en_w && !pipe_flush_w) drain_w++;
      step();
    end
    check("wdog_done", 64'(done_w), 64'd1);
    check("wdog_run_cycles_seen", 64'(run_cnt), 64'd15);
    check("wdog_no_drain", 64'(drain_w), 64'd0);
    check("wdog_err", 64'(err_w), 64'd2);
    check("wdog_run_cycles", 64'(run_cycles_w), 64'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
